// File: rtl/sram_apb_ctrl.sv
// APB slave bridging single-word transfers onto an asynchronous-ready SRAM port.
// One transfer at a time; strobes and APB responses are all registered.
module sram_apb_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int SRAM_DEPTH     = 160,
    parameter int TIMEOUT        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      we_n,
    output logic                      read_n,
    output logic [APB_ADDR_WIDTH-1:0] w_addr,
    output logic [APB_ADDR_WIDTH-1:0] r_addr,
    output logic [31:0]               write_data,
    input  logic                      ry,
    input  logic [31:0]               data_out
);

    // state | meaning
    // IDLE  | waiting for an APB access phase
    // WR    | write strobe low for one cycle
    // RD    | read strobe low for one cycle
    // WAIT  | waiting for ry, bounded by TIMEOUT cycles
    // DONE  | PREADY with PSLVERR=0 for one cycle
    // ERR   | PREADY with PSLVERR=1, PRDATA cleared
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [APB_ADDR_WIDTH:0] DEPTH_L  = (APB_ADDR_WIDTH + 1)'(SRAM_DEPTH);

    state_t                    state;
    logic [CNT_W-1:0]          wait_cnt;
    logic                      is_read;
    logic [APB_ADDR_WIDTH-1:0] index;
    logic                      in_range;
    logic                      access;

    assign index    = PADDR >> 2;
    assign in_range = ({1'b0, index} < DEPTH_L);
    assign access   = PSEL && PENABLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            is_read    <= 1'b0;
            we_n       <= 1'b1;
            read_n     <= 1'b1;
            w_addr     <= '0;
            r_addr     <= '0;
            write_data <= '0;
            PRDATA     <= '0;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (!in_range) begin
                            state   <= ERR;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                            PRDATA  <= '0;
                        end else if (PWRITE) begin
                            state      <= WR;
                            we_n       <= 1'b0;
                            w_addr     <= index;
                            write_data <= PWDATA;
                            is_read    <= 1'b0;
                        end else begin
                            state   <= RD;
                            read_n  <= 1'b0;
                            r_addr  <= index;
                            is_read <= 1'b1;
                        end
                    end
                end
                WR, RD: begin
                    we_n     <= 1'b1;
                    read_n   <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (ry) begin
                        state   <= DONE;
                        PREADY  <= 1'b1;
                        PSLVERR <= 1'b0;
                        // SRAM data is valid while ry is seen, so capture on this edge
                        if (is_read) begin
                            PRDATA <= data_out;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        state   <= ERR;
                        PREADY  <= 1'b1;
                        PSLVERR <= 1'b1;
                        PRDATA  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    we_n   <= 1'b1;
                    read_n <= 1'b1;
                    PREADY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_apb_ctrl.sv
// Scoreboard bench for sram_apb_ctrl: stimulus pushes expected strobes and responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sram_apb_ctrl;

    localparam int AW    = 12;
    localparam int DEPTH = 160;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic          we_n, read_n;
    logic [AW-1:0] w_addr, r_addr;
    logic [31:0]   write_data;
    logic          ry;
    logic [31:0]   data_out;

    always #5 clk = ~clk;

    sram_apb_ctrl #(.APB_ADDR_WIDTH(AW), .SRAM_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .we_n(we_n), .read_n(read_n), .w_addr(w_addr), .r_addr(r_addr),
        .write_data(write_data), .ry(ry), .data_out(data_out)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM environment: ry rises ry_delay cycles after the strobe cycle.
    int          ry_delay = 0;
    int          since = 0;
    logic [31:0] mem_sram [0:(1<<AW)-1];
    assign ry = (since >= ry_delay);
    always @(posedge clk) begin
        if (!we_n || !read_n) since <= 0;
        else if (since < 1000) since <= since + 1;
        if (!we_n)   mem_sram[w_addr] <= write_data;
        if (!read_n) data_out <= mem_sram[r_addr];
    end

    // Reference model
    logic [31:0] mem_ref [0:DEPTH-1];
    logic [31:0] last_prdata = 32'h0;

    typedef struct { logic slverr; logic [31:0] prdata; int cycle; } resp_t;
    typedef struct { logic wr; logic [AW-1:0] addr; logic [31:0] data; int cycle; } strb_t;
    resp_t resp_q[$];
    strb_t strb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!we_n || !read_n) begin
                chk("strobe_exclusive", {31'b0, we_n | read_n}, 32'h1);
                if (strb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: we_n=%0b read_n=%0b with none expected (cycle %0d)",
                             we_n, read_n, cyc);
                end else begin
                    strb_t s;
                    s = strb_q.pop_front();
                    chk("strobe_kind", {31'b0, !we_n}, {31'b0, s.wr});
                    chk("strobe_addr", {20'b0, s.wr ? w_addr : r_addr}, {20'b0, s.addr});
                    if (s.wr) chk("strobe_wdata", write_data, s.data);
                    chk("strobe_cycle", cyc, s.cycle);
                end
            end
            if (PREADY) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pready: PREADY=1 with none expected (cycle %0d)", cyc);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("pslverr", {31'b0, PSLVERR}, {31'b0, r.slverr});
                    chk("prdata", PRDATA, r.prdata);
                    chk("pready_cycle", cyc, r.cycle);
                end
            end
        end
    end

    task automatic start(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data,
                         input int delay, input int setup_len);
        int    idx, t;
        resp_t r;
        strb_t s;
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        ry_delay = delay;
        repeat (setup_len) @(negedge clk);
        PENABLE = 1'b1;
        t = cyc;
        idx = int'(addr) >> 2;
        if (idx >= DEPTH) begin
            last_prdata = 32'h0;
            r = '{1'b1, 32'h0, t + 1};
        end else begin
            s = '{wr, AW'(idx), data, t + 1};
            strb_q.push_back(s);
            if (wr) mem_ref[idx] = data;
            if (delay >= TMO) begin
                last_prdata = 32'h0;
                r = '{1'b1, 32'h0, t + TMO + 2};
            end else begin
                if (!wr) last_prdata = mem_ref[idx];
                r = '{1'b0, last_prdata, t + 3 + delay};
            end
        end
        resp_q.push_back(r);
    endtask

    task automatic finish_xfer();
        int n = 0;
        while (!PREADY && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!PREADY) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: PREADY=0 after %0d cycles, required 1", n);
            resp_q.delete();
            strb_q.delete();
            PSEL = 1'b0; PENABLE = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            PSEL = 1'b0; PENABLE = 1'b0;
        end
    endtask

    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data,
                        input int delay);
        start(wr, addr, data, delay, 1);
        finish_xfer();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we_n"}, {31'b0, we_n}, 32'h1);
        chk({tag, "_read_n"}, {31'b0, read_n}, 32'h1);
        chk({tag, "_w_addr"}, {20'b0, w_addr}, 32'h0);
        chk({tag, "_r_addr"}, {20'b0, r_addr}, 32'h0);
        chk({tag, "_write_data"}, write_data, 32'h0);
        chk({tag, "_prdata"}, PRDATA, 32'h0);
        chk({tag, "_pready"}, {31'b0, PREADY}, 32'h0);
        chk({tag, "_pslverr"}, {31'b0, PSLVERR}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit          wr;
        logic [AW-1:0] addr;
        logic [31:0] data;
        int          d, sel;

        for (int i = 0; i < DEPTH; i++) begin
            mem_ref[i]  = $urandom;
            mem_sram[i] = mem_ref[i];
        end
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("init");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        xfer(1'b1, 12'h010, 32'hDEADBEEF, 0);
        xfer(1'b0, 12'h010, 32'h0, 0);
        xfer(1'b0, 12'h280, 32'h0, 0);
        xfer(1'b0, 12'h020, 32'h0, 255);
        xfer(1'b1, 12'h024, 32'h12345678, 3);
        xfer(1'b1, 12'h27F, 32'hA5A5_0F0F, 0);
        xfer(1'b0, 12'h27C, 32'h0, 1);
        xfer(1'b1, 12'hFFC, 32'h1, 0);
        xfer(1'b0, 12'h026, 32'h0, TMO - 1);

        // Reset in the middle of a waiting transfer
        start(1'b0, 12'h030, 32'h0, 255, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("abort");
        chk("abort_strobe_pending", strb_q.size(), 32'h0);
        resp_q.delete();
        last_prdata = 32'h0;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        xfer(1'b0, 12'h024, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 3);
            addr = (sel == 0) ? AW'($urandom_range(0, 12'h2FF))
                              : AW'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            data = $urandom;
            sel  = $urandom_range(0, 9);
            d    = (sel == 9) ? 255 : (sel < 4) ? 0 : $urandom_range(1, 5);
            start(wr, addr, data, d, $urandom_range(1, 3));
            finish_xfer();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("resp_q_drained", resp_q.size(), 32'h0);
        chk("strb_q_drained", strb_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
